// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage with PC, instruction buffer, redirect and halt detection
module ifetch_unit #(
  parameter int              AW        = 8,
  parameter int              DW        = 32,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter int              DEPTH     = 2,
  parameter logic [DW-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic [AW-1:0] pmem_addr_o,
  input  logic [DW-1:0] pmem_data_i,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] instr_pc_o,
  output logic          instr_valid_o,
  input  logic          instr_ready_i,
  output logic          halted_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;

  state_e        state_q, state_d;
  logic          halted_q;
  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [AW-1:0] tag_q  [DEPTH];
  logic [AW-1:0] tag_d  [DEPTH];

  logic          pop;
  logic          push;

  // Handshake decode, buffer/PC next-state; redirect overrides any push and flushes the buffer
  always_comb begin
    pop     = (count_q != '0) && instr_ready_i;
    push    = (state_q == RUN) && en_i && !redirect_i &&
              ((count_q < CW'(DEPTH)) || pop);
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        data_d[wptr_q] = pmem_data_i;
        tag_d[wptr_q]  = pc_q;
        pc_d           = pc_q + AW'(1);
        wptr_d         = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state transitions; a pushed halt word stops fetching, redirect is the only exit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!redirect_i && en_i) state_d = RUN;
      RUN: begin
        if (!en_i)                                   state_d = IDLE;
        else if (push && (pmem_data_i == HALT_WORD)) state_d = HALTED;
      end
      HALTED:  if (redirect_i) state_d = en_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state with registered halt flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // PC, pointers and buffer storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= RESET_PC;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign pmem_addr_o   = pc_q;
  assign instr_o       = data_q[rptr_q];
  assign instr_pc_o    = tag_q[rptr_q];
  assign instr_valid_o = (count_q != '0);
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [7:0]  redirect_pc_i = '0;
  logic [7:0]  pmem_addr_o;
  logic [31:0] pmem_data_i;
  logic [31:0] instr_o;
  logic [7:0]  instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        halted_o;

  logic [31:0] mem [256];
  logic [39:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          hs = 0;

  always #5 clk = ~clk;

  assign pmem_data_i = mem[pmem_addr_o];

  ifetch_unit dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .en_i(en_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .pmem_addr_o(pmem_addr_o),
    .pmem_data_i(pmem_data_i),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .halted_o(halted_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected stream of consecutive PCs starting at start
  task automatic expect_run(input logic [7:0] start, input int n);
    logic [7:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, mem[p]});
      p = p + 8'd1;
    end
  endtask

  // one clock cycle; any head handshake is checked against the scoreboard
  task automatic cyc();
    logic [39:0] e;
    @(negedge clk);
    if (instr_valid_o && instr_ready_i) begin
      hs++;
      if (exp_q.size() == 0) begin
        chk("sb_extra", {56'd0, instr_pc_o}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", {56'd0, instr_pc_o}, {56'd0, e[39:32]});
        chk("sb_data", {32'd0, instr_o}, {32'd0, e[31:0]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic redir(input logic [7:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    cyc();
    redirect_i    = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    en_i   = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;

    // reset state
    #3;
    chk("rst_valid", {63'd0, instr_valid_o}, 64'd0);
    chk("rst_addr", {56'd0, pmem_addr_o}, 64'd0);
    chk("rst_instr", {32'd0, instr_o}, 64'd0);
    chk("rst_pc", {56'd0, instr_pc_o}, 64'd0);
    chk("rst_halted", {63'd0, halted_o}, 64'd0);
    do_reset();

    // streaming at one instruction per cycle
    en_i = 1'b1;
    instr_ready_i = 1'b1;
    expect_run(8'd0, 20);
    hs = 0;
    cycles(10);
    chk("t1_throughput", hs, 8);

    // back-pressure: buffer fills, PC stalls, then drains without gaps
    do_reset();
    en_i = 1'b1;
    instr_ready_i = 1'b0;
    cycles(5);
    chk("t2_stall_addr", {56'd0, pmem_addr_o}, 64'd2);
    chk("t2_valid", {63'd0, instr_valid_o}, 64'd1);
    chk("t2_head_data", {32'd0, instr_o}, 64'h100);
    chk("t2_head_pc", {56'd0, instr_pc_o}, 64'd0);
    instr_ready_i = 1'b1;
    expect_run(8'd0, 20);
    hs = 0;
    cycles(6);
    chk("t2_backtoback", hs, 6);

    // redirect with full buffer
    instr_ready_i = 1'b0;
    cycles(2);
    chk("t3_full_valid", {63'd0, instr_valid_o}, 64'd1);
    redir(8'h40);
    chk("t3_flush_valid", {63'd0, instr_valid_o}, 64'd0);
    expect_run(8'h40, 8);
    cyc();
    chk("t3_new_valid", {63'd0, instr_valid_o}, 64'd1);
    chk("t3_new_pc", {56'd0, instr_pc_o}, 64'h40);
    chk("t3_new_data", {32'd0, instr_o}, 64'h140);

    // PC wrap across 0xFF
    instr_ready_i = 1'b1;
    redir(8'hFE);
    expect_run(8'hFE, 8);
    hs = 0;
    cycles(4);
    chk("t4_wrap_hs", hs, 3);

    // halt word stops fetch after delivery
    mem[3] = 32'hFFFF_FFFF;
    redir(8'h00);
    expect_run(8'h00, 4);
    cycles(5);
    chk("t5_halted", {63'd0, halted_o}, 64'd1);
    cycles(3);
    chk("t5_halt_addr", {56'd0, pmem_addr_o}, 64'd4);
    chk("t5_no_valid", {63'd0, instr_valid_o}, 64'd0);
    chk("t5_drained", exp_q.size(), 0);
    redir(8'h00);
    expect_run(8'h00, 4);
    cycles(8);
    chk("t5_resume_drained", exp_q.size(), 0);
    chk("t5_rehalted", {63'd0, halted_o}, 64'd1);
    mem[3] = 32'h103;

    // asynchronous reset mid-cycle
    instr_ready_i = 1'b0;
    redir(8'h00);
    cycles(4);
    chk("t6_pre_valid", {63'd0, instr_valid_o}, 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_async_valid", {63'd0, instr_valid_o}, 64'd0);
    chk("t6_async_addr", {56'd0, pmem_addr_o}, 64'd0);
    chk("t6_async_instr", {32'd0, instr_o}, 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    en_i = 1'b0;
    instr_ready_i = 1'b1;
    exp_q.delete();
    hs = 0;
    cycles(3);
    chk("t6_idle_hs", hs, 0);
    chk("t6_idle_addr", {56'd0, pmem_addr_o}, 64'd0);
    en_i = 1'b1;
    expect_run(8'h00, 10);
    cycles(6);
    chk("t6_restart_hs", hs, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
